// File: rtl/fault_class_debouncer_if.sv
// Bus between the classifier side and the fault-class debouncer.
//   in_valid / in_cls / trip_clr   : driven by the master (classifier side)
//   out_valid / out_cls            : confirmed class state
//   event_pulse                    : one-cycle change/first-confirm pulse
//   trip / trip_cls                : sticky protection trip and the class that set it
//   evt_cnt                        : saturating count of nonzero confirmations
//   err_invalid                    : sticky out-of-range class flag
interface fault_class_debouncer_if #(
  parameter int unsigned C     = 3,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [C-1:0]     in_cls;
  logic             trip_clr;
  logic             out_valid;
  logic [C-1:0]     out_cls;
  logic             event_pulse;
  logic             trip;
  logic [C-1:0]     trip_cls;
  logic [CNT_W-1:0] evt_cnt;
  logic             err_invalid;

  modport master (
    output in_valid, in_cls, trip_clr,
    input  out_valid, out_cls, event_pulse, trip, trip_cls, evt_cnt, err_invalid
  );

  modport slave (
    input  in_valid, in_cls, trip_clr,
    output out_valid, out_cls, event_pulse, trip, trip_cls, evt_cnt, err_invalid
  );
endinterface

// File: rtl/fault_class_debouncer.sv
// Fault-class debouncer: confirms a raw classifier class only after CONFIRM
// consecutive identical valid samples, publishes the confirmed class, pulses an
// event on each change, counts nonzero confirmations and latches a trip on the
// first confirmed fault.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fault_class_debouncer_if.slave (inputs in_valid/in_cls/trip_clr,
//                registered outputs out_valid/out_cls/event_pulse/trip/trip_cls/
//                evt_cnt/err_invalid)
module fault_class_debouncer #(
  parameter int unsigned C       = 3,
  parameter int unsigned NUM_CLS = 6,
  parameter int unsigned CONFIRM = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fault_class_debouncer_if.slave  bus
);

  localparam int unsigned RUN_W = 8;
  localparam logic [RUN_W-1:0] CONFIRM_R = RUN_W'(CONFIRM);
  localparam logic [C:0]       NUM_CLS_X = (C+1)'(NUM_CLS);

  typedef enum logic {IDLE, STABLE} state_t;

  state_t           state_q, state_d;
  logic [C-1:0]     cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             out_valid_q, out_valid_d;
  logic [C-1:0]     out_cls_q, out_cls_d;
  logic             event_q, event_d;
  logic             trip_q, trip_d;
  logic [C-1:0]     trip_cls_q, trip_cls_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             err_q, err_d;

  logic             cls_ok;
  logic             confirm;
  logic [RUN_W-1:0] run_upd;

  // State register and all output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      run_q       <= '0;
      out_valid_q <= 1'b0;
      out_cls_q   <= '0;
      event_q     <= 1'b0;
      trip_q      <= 1'b0;
      trip_cls_q  <= '0;
      evt_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      out_cls_q   <= out_cls_d;
      event_q     <= event_d;
      trip_q      <= trip_d;
      trip_cls_q  <= trip_cls_d;
      evt_cnt_q   <= evt_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state: run tracking, confirmation and published outputs
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    run_d       = run_q;
    out_valid_d = out_valid_q;
    out_cls_d   = out_cls_q;
    event_d     = 1'b0;
    trip_d      = trip_q;
    trip_cls_d  = trip_cls_q;
    evt_cnt_d   = evt_cnt_q;
    err_d       = err_q;
    confirm     = 1'b0;
    run_upd     = run_q;
    cls_ok      = ({1'b0, bus.in_cls} < NUM_CLS_X);

    // Clear first so a same-cycle confirmation below overrides it
    if (bus.trip_clr) begin
      trip_d     = 1'b0;
      trip_cls_d = '0;
    end

    if (bus.in_valid) begin
      if (!cls_ok) begin
        err_d = 1'b1;
        run_d = '0;
      end else begin
        if ((bus.in_cls == cand_q) && (run_q != '0)) begin
          run_upd = (run_q < CONFIRM_R) ? run_q + RUN_W'(1) : CONFIRM_R;
          // Only the edge that first reaches CONFIRM confirms
          confirm = (run_upd == CONFIRM_R) && (run_q != CONFIRM_R);
        end else begin
          cand_d  = bus.in_cls;
          run_upd = RUN_W'(1);
          confirm = (CONFIRM_R == RUN_W'(1));
        end
        run_d = run_upd;

        if (confirm && ((state_q == IDLE) || (bus.in_cls != out_cls_q))) begin
          state_d     = STABLE;
          out_valid_d = 1'b1;
          out_cls_d   = bus.in_cls;
          event_d     = 1'b1;
          if (bus.in_cls != '0) begin
            if (evt_cnt_q != '1) begin
              evt_cnt_d = evt_cnt_q + CNT_W'(1);
            end
            if (!trip_q || bus.trip_clr) begin
              trip_d     = 1'b1;
              trip_cls_d = bus.in_cls;
            end
          end
        end
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_cls     = out_cls_q;
  assign bus.event_pulse = event_q;
  assign bus.trip        = trip_q;
  assign bus.trip_cls    = trip_cls_q;
  assign bus.evt_cnt     = evt_cnt_q;
  assign bus.err_invalid = err_q;

endmodule

// File: tb/tb_fault_class_debouncer.sv
// Bench for fault_class_debouncer: table of stimulus/expected-output records
// for the CONFIRM=4 instance, plus a short hand-written sequence on a
// CONFIRM=1, CNT_W=2 instance for per-sample confirmation and count saturation.
module tb_fault_class_debouncer;

  typedef struct packed {
    logic       ov;
    logic [2:0] oc;
    logic       ev;
    logic       tr;
    logic [2:0] tc;
    logic [7:0] cnt;
    logic       err;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       v;
    logic [2:0] cls;
    logic       clr;
    outs_t      exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    checks = 0;
  int    errors = 0;
  outs_t sb[$];
  vec_t  tbl[$];

  always #5 clk = ~clk;

  fault_class_debouncer_if #(.C(3), .CNT_W(8)) bus_a ();
  fault_class_debouncer_if #(.C(3), .CNT_W(2)) bus_b ();

  fault_class_debouncer #(.C(3), .NUM_CLS(6), .CONFIRM(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));

  fault_class_debouncer #(.C(3), .NUM_CLS(6), .CONFIRM(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  function automatic outs_t get_a();
    outs_t o;
    o.ov = bus_a.out_valid; o.oc = bus_a.out_cls; o.ev = bus_a.event_pulse;
    o.tr = bus_a.trip; o.tc = bus_a.trip_cls; o.cnt = bus_a.evt_cnt;
    o.err = bus_a.err_invalid;
    return o;
  endfunction

  function automatic outs_t get_b();
    outs_t o;
    o.ov = bus_b.out_valid; o.oc = bus_b.out_cls; o.ev = bus_b.event_pulse;
    o.tr = bus_b.trip; o.tc = bus_b.trip_cls; o.cnt = {6'b0, bus_b.evt_cnt};
    o.err = bus_b.err_invalid;
    return o;
  endfunction

  function automatic outs_t mk_o(logic ov, logic [2:0] oc, logic ev, logic tr,
                                 logic [2:0] tc, logic [7:0] cnt, logic err);
    outs_t o;
    o.ov = ov; o.oc = oc; o.ev = ev; o.tr = tr; o.tc = tc; o.cnt = cnt; o.err = err;
    return o;
  endfunction

  function automatic vec_t mk(logic rst, logic v, logic [2:0] cls, logic clr,
                              logic ov, logic [2:0] oc, logic ev, logic tr,
                              logic [2:0] tc, logic [7:0] cnt, logic err);
    vec_t r;
    r.rst = rst; r.v = v; r.cls = cls; r.clr = clr;
    r.exp = mk_o(ov, oc, ev, tr, tc, cnt, err);
    return r;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ov=%0b cls=%0d ev=%0b trip=%0b tcls=%0d cnt=%0d err=%0b, expected ov=%0b cls=%0d ev=%0b trip=%0b tcls=%0d cnt=%0d err=%0b",
               name, act.ov, act.oc, act.ev, act.tr, act.tc, act.cnt, act.err,
               exp.ov, exp.oc, exp.ev, exp.tr, exp.tc, exp.cnt, exp.err);
    end
  endtask

  task automatic idle_inputs();
    bus_a.in_valid = 1'b0; bus_a.in_cls = 3'd0; bus_a.trip_clr = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_cls = 3'd0; bus_b.trip_clr = 1'b0;
  endtask

  // Drive one sample on instance a (0) or b (1); expected result goes to the
  // scoreboard at drive time and is popped once the edge has been taken.
  task automatic apply(input int which, input logic v, input logic [2:0] cls,
                       input logic clr, input outs_t exp, input string name);
    outs_t e;
    @(negedge clk);
    idle_inputs();
    if (which == 0) begin
      bus_a.in_valid = v; bus_a.in_cls = cls; bus_a.trip_clr = clr;
    end else begin
      bus_b.in_valid = v; bus_b.in_cls = cls; bus_b.trip_clr = clr;
    end
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got nothing expected one entry", name);
    end else begin
      e = sb.pop_front();
      check(name, (which == 0) ? get_a() : get_b(), e);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("reset_mid_a", get_a(), '0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Confirm 2 (trip set), glitchy 5 then 0
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,2,0, 0,0,0,0,0,8'd0,0));
    tbl.push_back(mk(0,1,2,0, 1,2,1,1,2,8'd1,0));
    tbl.push_back(mk(0,1,2,0, 1,2,0,1,2,8'd1,0));
    tbl.push_back(mk(0,1,5,0, 1,2,0,1,2,8'd1,0));
    tbl.push_back(mk(0,1,5,0, 1,2,0,1,2,8'd1,0));
    tbl.push_back(mk(0,1,3,0, 1,2,0,1,2,8'd1,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,5,0, 1,2,0,1,2,8'd1,0));
    tbl.push_back(mk(0,1,5,0, 1,5,1,1,2,8'd2,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,0, 1,5,0,1,2,8'd2,0));
    tbl.push_back(mk(0,1,0,0, 1,0,1,1,2,8'd2,0));
    // Invalid code breaks the run
    tbl.push_back(mk(0,1,2,0, 1,0,0,1,2,8'd2,0));
    tbl.push_back(mk(0,1,2,0, 1,0,0,1,2,8'd2,0));
    tbl.push_back(mk(0,1,7,0, 1,0,0,1,2,8'd2,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,2,0, 1,0,0,1,2,8'd2,1));
    tbl.push_back(mk(0,1,2,0, 1,2,1,1,2,8'd3,1));
    // Trip clear racing a nonzero confirmation, then a plain clear
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,1,0, 1,2,0,1,2,8'd3,1));
    tbl.push_back(mk(0,1,1,1, 1,1,1,1,1,8'd4,1));
    tbl.push_back(mk(0,0,0,1, 1,1,0,0,0,8'd4,1));
    tbl.push_back(mk(0,0,0,0, 1,1,0,0,0,8'd4,1));
    // in_valid gaps do not break a run; re-trip after clear
    tbl.push_back(mk(0,1,3,0, 1,1,0,0,0,8'd4,1));
    tbl.push_back(mk(0,0,3,0, 1,1,0,0,0,8'd4,1));
    tbl.push_back(mk(0,1,3,0, 1,1,0,0,0,8'd4,1));
    tbl.push_back(mk(0,1,3,0, 1,1,0,0,0,8'd4,1));
    tbl.push_back(mk(0,1,3,0, 1,3,1,1,3,8'd5,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,3,0, 1,3,0,1,3,8'd5,1));
    // Reset mid-count: run restarts from zero
    tbl.push_back(mk(1,1,3,0, 0,0,0,0,0,8'd0,0));
    tbl.push_back(mk(0,1,3,0, 0,0,0,0,0,8'd0,0));
    tbl.push_back(mk(0,1,3,0, 0,0,0,0,0,8'd0,0));
    tbl.push_back(mk(0,1,3,0, 1,3,1,1,3,8'd1,0));
    // Code equal to NUM_CLS is already invalid
    tbl.push_back(mk(0,1,6,0, 1,3,0,1,3,8'd1,1));

    // Reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_a.in_valid = 1'($urandom); bus_a.in_cls = 3'($urandom); bus_a.trip_clr = 1'($urandom);
      bus_b.in_valid = 1'($urandom); bus_b.in_cls = 3'($urandom); bus_b.trip_clr = 1'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("reset_a%0d", i), get_a(), '0);
      check($sformatf("reset_b%0d", i), get_b(), '0);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) apply(0, 1'b0, 3'd0, 1'b0, '0, $sformatf("idle%0d", i));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) pulse_reset();
      apply(0, tbl[i].v, tbl[i].cls, tbl[i].clr, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // CONFIRM=1 instance: every new class confirms, count saturates at 3
    apply(1, 1'b1, 3'd1, 1'b0, mk_o(1,1,1,1,1,8'd1,0), "b_c1");
    apply(1, 1'b1, 3'd4, 1'b0, mk_o(1,4,1,1,1,8'd2,0), "b_c4");
    apply(1, 1'b1, 3'd1, 1'b0, mk_o(1,1,1,1,1,8'd3,0), "b_c1b");
    apply(1, 1'b1, 3'd4, 1'b0, mk_o(1,4,1,1,1,8'd3,0), "b_sat4");
    apply(1, 1'b1, 3'd1, 1'b0, mk_o(1,1,1,1,1,8'd3,0), "b_sat1");
    apply(1, 1'b1, 3'd1, 1'b0, mk_o(1,1,0,1,1,8'd3,0), "b_repeat");
    apply(1, 1'b1, 3'd0, 1'b0, mk_o(1,0,1,1,1,8'd3,0), "b_zero");
    apply(1, 1'b0, 3'd0, 1'b0, mk_o(1,0,0,1,1,8'd3,0), "b_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
